// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a length/payload/checksum frame into 32-bit
// instruction-memory writes and holds the core in reset until a good load completes.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

    state_t      state, state_nxt;
    logic [7:0]  n_lo;
    logic [15:0] n_len;
    logic [1:0]  byte_idx;
    logic [23:0] wbuf;
    logic [7:0]  csum;
    logic        acc;
    logic        start_go;
    logic        last_byte;
    logic [16:0] n_new;

    assign acc       = in_valid & in_ready;
    assign start_go  = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    assign n_new     = {1'b0, in_data, n_lo};
    // Fourth byte of the final word ends the payload.
    assign last_byte = (byte_idx == 2'd3) && (({1'b0, word_cnt} + 17'd1) == {1'b0, n_len});

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start_go) state_nxt = LEN0;
            LEN0: if (acc) state_nxt = LEN1;
            LEN1: if (acc) begin
                if (n_new > MAX_N)       state_nxt = ERR;
                else if (n_new == 17'd0) state_nxt = CSUM;
                else                     state_nxt = DATA;
            end
            DATA: if (acc && last_byte) state_nxt = CSUM;
            CSUM: if (acc) state_nxt = (in_data == csum) ? DONE : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        case (state)
            LEN0, LEN1, DATA, CSUM: in_ready = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_cnt   <= '0;
            csum       <= '0;
            n_lo       <= '0;
            n_len      <= '0;
            byte_idx   <= '0;
            wbuf       <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_go) begin
                word_cnt <= '0;
                csum     <= '0;
                byte_idx <= '0;
            end
            if (acc) begin
                case (state)
                    LEN0: n_lo  <= in_data;
                    LEN1: n_len <= n_new[15:0];
                    DATA: begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: wbuf[7:0]   <= in_data;
                            2'd1: wbuf[15:8]  <= in_data;
                            2'd2: wbuf[23:16] <= in_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_cnt[ADDR_W-1:0];
                                imem_wdata <= {in_data, wbuf};
                                word_cnt   <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected writes, a monitor
// pops and compares them whenever imem_we fires.
module tb_prog_loader;
    localparam int ADDR_W = 10;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [15:0]       word_cnt;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk1(clk1), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk1 = ~clk1;

    int n_chk = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] q_addr[$];
    logic [31:0]       q_data[$];
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_data;
    logic [7:0]        fr [0:14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk1) begin
        if (imem_we === 1'b1) begin
            if (q_addr.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %08h expected no write", imem_addr, imem_wdata);
            end else begin
                m_addr = q_addr.pop_front();
                m_data = q_data.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(m_addr));
                chk("write_data", imem_wdata, m_data);
                chk("write_cnt", 32'(word_cnt), 32'(m_addr) + 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_w(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        q_addr.push_back(a);
        q_data.push_back(d);
    endtask

    task automatic push_ref(input int n);
        if (n > 0) expect_w(0, 32'h00a00093);
        if (n > 1) expect_w(1, 32'h01400113);
        if (n > 2) expect_w(2, 32'h01900193);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk1);
            if (in_ready === 1'b1) break;
            @(posedge clk1);
            #1;
        end
        if (k == 50) begin
            n_chk++;
            n_err++;
            $display("FAIL byte_timeout: byte %02h not accepted within 50 cycles", b);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int nbytes, input int gap, input int start_at, input logic [7:0] cs);
        for (int i = 0; i < nbytes; i++) begin
            if (i == start_at) do_start();
            send_byte((i == 14) ? cs : fr[i], gap);
        end
    endtask

    task automatic check_status(input string name, input logic d, input logic e,
                                input logic h, input int wc, input logic r);
        @(negedge clk1);
        chk({name, "_done"}, 32'(done), 32'(d));
        chk({name, "_err"}, 32'(err), 32'(e));
        chk({name, "_hold"}, 32'(cpu_hold), 32'(h));
        chk({name, "_wcnt"}, 32'(word_cnt), 32'(wc));
        chk({name, "_ready"}, 32'(in_ready), 32'(r));
        @(posedge clk1);
        #1;
    endtask

    task automatic check_reset(input string name);
        chk({name, "_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_we"}, 32'(imem_we), 32'd0);
        chk({name, "_addr"}, 32'(imem_addr), 32'd0);
        chk({name, "_wdata"}, imem_wdata, 32'd0);
        chk({name, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
        chk({name, "_wcnt"}, 32'(word_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fr = '{8'h03, 8'h00, 8'h93, 8'h00, 8'ha0, 8'h00, 8'h13, 8'h01,
               8'h40, 8'h01, 8'h93, 8'h01, 8'h90, 8'h01, 8'h63};
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk1);
        check_reset("por");
        @(posedge clk1); #1;
        rst = 1'b0;
        tick();

        // good load
        do_start();
        check_status("arm", 1'b0, 1'b0, 1'b1, 0, 1'b1);
        push_ref(3);
        send_frame(15, 0, -1, 8'h63);
        tick();
        check_status("good", 1'b1, 1'b0, 1'b0, 3, 1'b0);
        chk("good_drain", 32'(q_addr.size()), 32'd0);

        // empty program, armed from DONE
        do_start();
        check_status("rearm", 1'b0, 1'b0, 1'b1, 0, 1'b1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tick();
        check_status("empty", 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // bad checksum: writes stay, error flagged
        do_start();
        push_ref(3);
        send_frame(15, 0, -1, 8'h62);
        tick();
        check_status("badcs", 1'b0, 1'b1, 1'b1, 3, 1'b0);
        chk("badcs_drain", 32'(q_addr.size()), 32'd0);

        // oversize count 0x0401 > 1024
        do_start();
        check_status("arm_err", 1'b0, 1'b0, 1'b1, 0, 1'b1);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        tick();
        check_status("oversize", 1'b0, 1'b1, 1'b1, 0, 1'b0);

        // gapped stream with a stray start inside the payload
        do_start();
        push_ref(3);
        send_frame(15, 3, 6, 8'h63);
        tick();
        check_status("gaps", 1'b1, 1'b0, 1'b0, 3, 1'b0);
        chk("gaps_drain", 32'(q_addr.size()), 32'd0);

        // reset after the second word
        do_start();
        push_ref(2);
        send_frame(10, 0, -1, 8'h00);
        tick();
        rst = 1'b1;
        #1;
        check_reset("midrst");
        chk("midrst_drain", 32'(q_addr.size()), 32'd0);
        @(posedge clk1); #1;
        rst = 1'b0;
        tick();
        check_status("postrst", 1'b0, 1'b0, 1'b1, 0, 1'b0);
        do_start();
        push_ref(3);
        send_frame(15, 0, -1, 8'h63);
        tick();
        check_status("reload", 1'b1, 1'b0, 1'b0, 3, 1'b0);
        chk("reload_drain", 32'(q_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
